// File: rtl/ext_int_arbiter.sv
// ext_int_arbiter: priority external interrupt arbiter
// with per-source gateways and claim/complete handshake.
package ext_int_pkg;
  typedef struct packed {
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] wdata;
  } hb_slave_t;
  typedef struct packed {
    logic wen;
    logic ren;
  } sel_t;
endpackage

module ext_int_arbiter
  import ext_int_pkg::*;
#(
  parameter int INT_NUM = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_BASE = 16
) (
  input  logic               hb_clk,
  input  logic               rst_sync_n,
  input  hb_slave_t          xt_hb,
  input  sel_t               sel,
  output logic [31:0]        rdata,
  input  logic [INT_NUM-1:0] irq_source,
  output logic               mextern_int,
  output logic [30:0]        mextern_int_id
);

  localparam int PW = INT_NUM * PRIO_W;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PEND,
    GW_INFL
  } gw_e;

  gw_e gw_q [INT_NUM];
  gw_e gw_d [INT_NUM];

  logic [INT_NUM-1:0] enable_q, enable_d;
  logic [PRIO_W-1:0]  thresh_q, thresh_d;
  logic [PW-1:0]      prio_q, prio_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mint_q, mint_d;
  logic [30:0]        mid_q, mid_d;

  logic [INT_NUM-1:0] pend, elig;
  logic               win_found, best_valid;
  logic [3:0]         win_idx;
  logic [PRIO_W-1:0]  win_prio;
  logic [2:0]         rd_off, wr_off;
  logic               claim, cmpl;
  logic [7:0]         cmpl_id;
  logic               unused_bits;

  assign unused_bits = ^xt_hb;
  assign rd_off  = xt_hb.raddr[4:2];
  assign wr_off  = xt_hb.waddr[4:2];
  assign cmpl_id = xt_hb.wdata[7:0];

  always_comb begin
    pend      = '0;
    elig      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    // strict > keeps the lowest index on ties
    for (int i = 0; i < INT_NUM; i++) begin
      pend[i] = (gw_q[i] == GW_PEND);
      elig[i] = pend[i] & enable_q[i]
              & (prio_q[i*PRIO_W +: PRIO_W] != '0);
      if (elig[i] && (!win_found ||
          prio_q[i*PRIO_W +: PRIO_W] > win_prio)) begin
        win_found = 1'b1;
        win_idx   = 4'(i);
        win_prio  = prio_q[i*PRIO_W +: PRIO_W];
      end
    end
    best_valid = win_found && (win_prio > thresh_q);
  end

  assign claim = sel.ren && (rd_off == 3'd3) && best_valid;
  assign cmpl  = sel.wen && (wr_off == 3'd3);

  always_comb begin
    for (int i = 0; i < INT_NUM; i++) begin
      gw_d[i] = gw_q[i];
      unique case (gw_q[i])
        GW_IDLE: if (irq_source[i]) gw_d[i] = GW_PEND;
        GW_PEND: if (claim && win_idx == 4'(i))
                   gw_d[i] = GW_INFL;
        GW_INFL: if (cmpl && cmpl_id == 8'(i + 1))
                   gw_d[i] = GW_IDLE;
        default: gw_d[i] = GW_IDLE;
      endcase
    end
  end

  always_comb begin
    enable_d = enable_q;
    thresh_d = thresh_q;
    prio_d   = prio_q;
    if (sel.wen) begin
      unique case (wr_off)
        3'd0:    enable_d = xt_hb.wdata[INT_NUM-1:0];
        3'd2:    thresh_d = xt_hb.wdata[PRIO_W-1:0];
        3'd4:    prio_d   = xt_hb.wdata[PW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (sel.ren) begin
      unique case (rd_off)
        3'd0:    rdata_d = 32'(enable_q);
        3'd1:    rdata_d = 32'(pend);
        3'd2:    rdata_d = 32'(thresh_q);
        3'd3:    rdata_d = best_valid ?
                   32'(win_idx) + 32'd1 : 32'd0;
        3'd4:    rdata_d = 32'(prio_q);
        default: rdata_d = '0;
      endcase
    end
    mint_d = best_valid;
    mid_d  = 31'(ID_BASE) + 31'(win_idx);
  end

  always_ff @(posedge hb_clk) begin
    if (!rst_sync_n) begin
      for (int i = 0; i < INT_NUM; i++)
        gw_q[i] <= GW_IDLE;
      enable_q <= '0;
      thresh_q <= '0;
      prio_q   <= '0;
      rdata_q  <= '0;
      mint_q   <= 1'b0;
      mid_q    <= 31'(ID_BASE);
    end else begin
      for (int i = 0; i < INT_NUM; i++)
        gw_q[i] <= gw_d[i];
      enable_q <= enable_d;
      thresh_q <= thresh_d;
      prio_q   <= prio_d;
      rdata_q  <= rdata_d;
      mint_q   <= mint_d;
      mid_q    <= mid_d;
    end
  end

  assign rdata          = rdata_q;
  assign mextern_int    = mint_q;
  assign mextern_int_id = mid_q;

endmodule

// File: tb/tb_ext_int_arbiter.sv
// tb_ext_int_arbiter: directed checks of gateways,
// arbitration, claim/complete and reset.
module tb_ext_int_arbiter;
  import ext_int_pkg::*;

  localparam logic [31:0] A_EN   = 32'h00;
  localparam logic [31:0] A_PEND = 32'h04;
  localparam logic [31:0] A_THR  = 32'h08;
  localparam logic [31:0] A_CC   = 32'h0C;
  localparam logic [31:0] A_PRIO = 32'h10;

  logic        hb_clk = 1'b0;
  logic        rst_sync_n;
  hb_slave_t   xt_hb;
  sel_t        sel;
  logic [31:0] rdata;
  logic [7:0]  irq_source;
  logic        mextern_int;
  logic [30:0] mextern_int_id;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] d;

  always #5 hb_clk = ~hb_clk;

  ext_int_arbiter dut (
    .hb_clk         (hb_clk),
    .rst_sync_n     (rst_sync_n),
    .xt_hb          (xt_hb),
    .sel            (sel),
    .rdata          (rdata),
    .irq_source     (irq_source),
    .mextern_int    (mextern_int),
    .mextern_int_id (mextern_int_id)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge hb_clk);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] v);
    xt_hb.waddr = a;
    xt_hb.wdata = v;
    sel.wen = 1'b1;
    @(negedge hb_clk);
    sel.wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] v);
    xt_hb.raddr = a;
    sel.ren = 1'b1;
    @(negedge hb_clk);
    sel.ren = 1'b0;
    v = rdata;
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_source = m;
    @(negedge hb_clk);
    irq_source = '0;
  endtask

  initial begin
    rst_sync_n = 1'b0;
    xt_hb = '0;
    sel = '0;
    irq_source = '0;
    tick(2);
    rst_sync_n = 1'b1;
    chk("rst_mint", 32'(mextern_int), 0);
    chk("rst_mid", 32'(mextern_int_id), 16);
    chk("rst_rdata", rdata, 0);
    rd(A_EN, d);   chk("rst_en", d, 0);
    rd(A_PEND, d); chk("rst_pend", d, 0);
    rd(A_THR, d);  chk("rst_thr", d, 0);
    rd(A_PRIO, d); chk("rst_prio", d, 0);
    rd(32'h14, d); chk("rd_unmapped", d, 0);

    // single source, 2-edge latency
    wr(A_EN, 32'h01);
    wr(A_PRIO, 32'h1);
    irq_source = 8'h01;
    tick(1);
    irq_source = '0;
    chk("t1_lat1", 32'(mextern_int), 0);
    tick(1);
    chk("t1_lat2", 32'(mextern_int), 1);
    chk("t1_id", 32'(mextern_int_id), 16);
    rd(A_CC, d);   chk("t1_claim", d, 1);
    chk("t1_stale", 32'(mextern_int), 1);
    tick(1);
    chk("t1_drop", 32'(mextern_int), 0);
    wr(A_CC, 1);

    // tie at equal priority -> lowest index
    wr(A_EN, 32'hFF);
    wr(A_PRIO, (32'd3 << 6) | (32'd3 << 15));
    pulse(8'h24);
    tick(2);
    rd(A_CC, d);   chk("t2_claim_a", d, 3);
    rd(A_CC, d);   chk("t2_claim_b", d, 6);
    rd(A_CC, d);   chk("t2_claim_c", d, 0);
    wr(A_CC, 3);
    wr(A_CC, 6);

    // priority order and threshold
    wr(A_PRIO, (32'd2 << 3) | (32'd5 << 12));
    pulse(8'h12);
    tick(2);
    chk("t3_mint", 32'(mextern_int), 1);
    chk("t3_id", 32'(mextern_int_id), 20);
    rd(A_CC, d);   chk("t3_claim", d, 5);
    wr(A_THR, 5);
    tick(1);
    chk("t3_thr_mint", 32'(mextern_int), 0);
    rd(A_CC, d);   chk("t3_thr_claim", d, 0);
    rd(A_PEND, d); chk("t3_thr_pend", d, 32'h02);
    wr(A_THR, 1);
    tick(1);
    chk("t3_thr1_mint", 32'(mextern_int), 1);
    chk("t3_thr1_id", 32'(mextern_int_id), 17);
    rd(A_CC, d);   chk("t3_claim2", d, 2);
    wr(A_CC, 2);
    wr(A_CC, 5);
    wr(A_THR, 0);

    // held level blocked while in flight
    wr(A_PRIO, 32'd1 << 9);
    irq_source = 8'h08;
    tick(2);
    rd(A_CC, d);   chk("t4_claim", d, 4);
    tick(2);
    chk("t4_infl", 32'(mextern_int), 0);
    wr(A_CC, 7);
    tick(2);
    chk("t4_bad_cmpl", 32'(mextern_int), 0);
    rd(A_PEND, d); chk("t4_pend", d, 0);
    wr(A_CC, 4);
    tick(2);
    chk("t4_repend", 32'(mextern_int), 1);
    irq_source = '0;
    rd(A_CC, d);   chk("t4_claim2", d, 4);
    wr(A_CC, 4);

    // claim and complete of the same source together
    wr(A_PRIO, 32'd1);
    irq_source = 8'h01;
    tick(2);
    xt_hb.raddr = A_CC;
    xt_hb.waddr = A_CC;
    xt_hb.wdata = 1;
    sel = '{wen: 1'b1, ren: 1'b1};
    @(negedge hb_clk);
    sel = '0;
    chk("t5_claim", rdata, 1);
    tick(3);
    chk("t5_still_infl", 32'(mextern_int), 0);
    irq_source = '0;
    wr(A_CC, 1);

    // enable masks arbitration only
    pulse(8'h01);
    tick(2);
    chk("t6_mint", 32'(mextern_int), 1);
    wr(A_EN, 0);
    tick(1);
    chk("t6_masked", 32'(mextern_int), 0);
    rd(A_PEND, d); chk("t6_pend", d, 32'h01);
    wr(A_EN, 32'hFF);
    tick(1);
    chk("t6_unmask", 32'(mextern_int), 1);
    rd(A_CC, d);   chk("t6_claim", d, 1);
    wr(A_CC, 1);

    // reset drops in-flight state
    wr(A_PRIO, 32'd1 << 6);
    irq_source = 8'h04;
    tick(2);
    rd(A_CC, d);   chk("t7_claim", d, 3);
    rst_sync_n = 1'b0;
    tick(1);
    rst_sync_n = 1'b1;
    chk("t7_mint", 32'(mextern_int), 0);
    chk("t7_mid", 32'(mextern_int_id), 16);
    chk("t7_rdata", rdata, 0);
    rd(A_EN, d);   chk("t7_en", d, 0);
    rd(A_THR, d);  chk("t7_thr", d, 0);
    rd(A_PRIO, d); chk("t7_prio", d, 0);
    rd(A_PEND, d); chk("t7_repend", d, 32'h04);
    wr(A_EN, 32'h04);
    wr(A_PRIO, 32'd2 << 6);
    tick(1);
    chk("t7_mint_back", 32'(mextern_int), 1);
    chk("t7_id_back", 32'(mextern_int_id), 18);
    irq_source = '0;

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_int_arbiter.md
# ext_int_arbiter

Priority-based external interrupt arbiter with a claim/complete handshake. It sits between peripheral interrupt lines and the core's machine-external interrupt input, on the XT high-speed bus. Each source has its own gateway that latches a level request and holds it off until software completes it. The arbiter picks the highest-priority enabled pending source above a threshold and presents it to the core as `mextern_int` / `mextern_int_id`.

## Interface
- `INT_NUM`, 8: number of sources; legal range 1..8.
- `PRIO_W`, 3: priority width per source. `INT_NUM*PRIO_W` must be ≤ 32.
- `ID_BASE`, 16: offset added to the source index to form `mextern_int_id`.

Ports:
- `hb_clk`  in  1  bus/core clock; all logic is on its rising edge.
- `rst_sync_n`  in  1  reset, synchronous, active-low.
- `xt_hb`  in  hb_slave_t  bus slave signals (`waddr`, `raddr`, `wdata`).
- `sel`  in  sel_t  decoded select (`wen`, `ren`) for this block.
- `rdata`  out  32  registered read data.
- `irq_source`  in  INT_NUM  level-high interrupt requests, synchronous to `hb_clk`.
- `mextern_int`  out  1  registered external interrupt request to the core.
- `mextern_int_id`  out  31  registered ID of the current winner, `ID_BASE + index`.

## Operation
- Register map, word offset decoded from addr[4:2]:
  - 0x00 ENABLE: RW, `[INT_NUM-1:0]`.
  - 0x04 PENDING: RO.
  - 0x08 THRESHOLD: RW, `[PRIO_W-1:0]`.
  - 0x0C CLAIM/COMPLETE: read = claim, write = complete.
  - 0x10 PRIORITY: RW, packed, source i at bits `[i*PRIO_W +: PRIO_W]`.
  - Other offsets: reads return 0, writes are ignored. Unused read bits return 0.
- Gateway per source i, three states:
  - IDLE → PENDING when `irq_source[i]` is 1.
  - PENDING → INFLIGHT on a claim of i.
  - INFLIGHT → IDLE on a complete write with `wdata[7:0] == i+1`.
  - While INFLIGHT, the source is ignored, so a held level cannot re-pend until it is completed.
  - ENABLE does not gate the gateways. ENABLE only masks arbitration; a disabled source can still sit in PENDING.
- Eligible source: pending, enabled, and priority > 0.
- Winner: highest priority among eligible sources; ties go to the lowest index.
  - `best_valid` = winner exists AND winner priority > THRESHOLD.
- Claim read returns `best_valid ? winner+1 : 0`.
  - The claim acts on the winner evaluated in the read-request cycle.
  - A claim returning 0 has no side effect.
- Complete write:
  - Value 0, an out-of-range ID, or an ID whose gateway is not INFLIGHT is ignored.
- `mextern_int` is registered `best_valid`; `mextern_int_id` is registered `ID_BASE + winner`.
- PENDING read returns gateway-pending bits, unmasked by ENABLE.

## Timing
- Reset (`rst_sync_n` = 0 at an edge) produces:
  - ENABLE = 0, THRESHOLD = 0, PRIORITY = 0.
  - All gateways IDLE.
  - `mextern_int` = 0, `mextern_int_id` = `ID_BASE`, `rdata` = 0.
  - Reset during an in-flight handler drops all INFLIGHT state.
- Request path:
  - `irq_source` high at edge n sets PENDING at n.
  - `mextern_int` rises at edge n+1.
  - Source-to-core latency is 2 edges.
- Read path:
  - Read latency 1: `rdata` is loaded at the edge where `sel.ren` = 1 and holds otherwise.
  - A claim at edge c moves the gateway to INFLIGHT at c.
  - `mextern_int` / `mextern_int_id` reflect the post-claim winner at c+1. Software must tolerate one stale cycle.
- Write path:
  - Config and complete writes take effect at the `sel.wen` edge.
  - A completed source with its level still high re-enters PENDING at the next edge.
- Simultaneous claim read and complete write in the same cycle:
  - Both apply.
  - If both target the same source, complete is ignored because the source was not yet INFLIGHT; the claim wins.
- A source rising in the same cycle as a claim of a different source joins arbitration at the next edge.

## Test plan
- Reset, then ENABLE = 0x01, PRIORITY[0] = 1, pulse `irq_source[0]` for 1 cycle:
  - `mextern_int` = 1 two edges later, `mextern_int_id` = 16.
  - Claim returns 1; `mextern_int` = 0 one edge after the claim.
- Sources 2 and 5 both pending, ENABLE = 0xFF, priorities 3 and 3:
  - Claim returns 3.
  - Next claim returns 6.
- Sources 1 and 4 pending with priorities 2 and 5:
  - `mextern_int_id` = 20, claim returns 5.
  - With THRESHOLD = 5, `mextern_int` = 0 and claim returns 0 with no state change.
- Hold `irq_source[3]` high, then claim (returns 4):
  - `mextern_int` stays 0 while INFLIGHT.
  - Write complete 4: `mextern_int` = 1 again within 2 edges.
  - Write complete 7 while 3 is in flight: ignored.
- Pend source 0, then ENABLE = 0: `mextern_int` = 0 while PENDING still reads 0x01. Re-enabling restores `mextern_int` = 1.
- Claim source 2, then drive `rst_sync_n` = 0 for one edge:
  - All registers read 0 and `mextern_int` = 0.
  - A held `irq_source[2]` re-pends immediately after reset; it is not blocked by stale INFLIGHT state.
